// File: rtl/muldiv_ctrl_if.sv
// Pipeline <-> multiply/divide unit handshake bundle.
//   master (pipeline): drives start, op, a, b, flush, read_hilo;
//                      observes busy, done, stall, hi, lo.
//   slave  (muldiv):   the mirror image.
interface muldiv_ctrl_if #(
    parameter int unsigned WORD_LEN = 32
);
    logic                start;
    logic [1:0]          op;
    logic [WORD_LEN-1:0] a;
    logic [WORD_LEN-1:0] b;
    logic                flush;
    logic                read_hilo;
    logic                busy;
    logic                done;
    logic                stall;
    logic [WORD_LEN-1:0] hi;
    logic [WORD_LEN-1:0] lo;

    modport master (
        output start, op, a, b, flush, read_hilo,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, read_hilo,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style HI/LO multiply/divide unit with fixed 35-cycle latency.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - muldiv_ctrl_if.slave:
//          start/op/a/b   operation request, sampled only in IDLE
//                         (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//          flush          abort any in-flight operation (beats start in IDLE)
//          read_hilo      pipeline wants HI/LO this cycle
//          busy/done      not-IDLE / one-cycle result pulse
//          stall          pipeline interlock
//          hi/lo          result registers (product words, or remainder/quotient)
module muldiv_ctrl #(
    parameter int unsigned WORD_LEN = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(WORD_LEN) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WORD_LEN - 1);

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0]          op_q;
    logic [WORD_LEN-1:0] a_q, b_q;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [WORD_LEN-1:0] dvs_q, dvs_d;
    // acc_hi: partial product high word / partial remainder.
    // acc_lo: multiplier shifting out / dividend shifting out, quotient shifting in.
    logic [WORD_LEN-1:0] acc_hi_q, acc_hi_d;
    logic [WORD_LEN-1:0] acc_lo_q, acc_lo_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WORD_LEN-1:0] hi_q, lo_q;

    logic is_div, is_signed, capture, load_res;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign capture   = (state_q == StIdle) && bus.start && !bus.flush;

    // One shift-add multiply step; the extra bit carries out of the add.
    logic [WORD_LEN:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + ({1'b0, dvs_q} & {(WORD_LEN + 1){acc_lo_q[0]}});

    // One restoring divide step; the subtraction only fits in WORD_LEN bits when kept.
    logic [WORD_LEN:0]   div_rem;
    logic [WORD_LEN-1:0] div_sub;
    logic                div_ge;
    assign div_rem = {acc_hi_q, acc_lo_q[WORD_LEN-1]};
    assign div_ge  = div_rem >= {1'b0, dvs_q};
    assign div_sub = div_rem[WORD_LEN-1:0] - dvs_q;

    always_comb begin
        state_d  = state_q;
        dvs_d    = dvs_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (capture) state_d = StPrep;
            end
            StPrep: begin
                neg_a_d  = is_signed & a_q[WORD_LEN-1];
                neg_b_d  = is_signed & b_q[WORD_LEN-1];
                acc_hi_d = '0;
                acc_lo_d = neg_a_d ? -a_q : a_q;
                dvs_d    = neg_b_d ? -b_q : b_q;
                cnt_d    = '0;
                state_d  = StCalc;
            end
            StCalc: begin
                cnt_d = cnt_q + CntW'(1);
                if (is_div) begin
                    acc_hi_d = div_ge ? div_sub : div_rem[WORD_LEN-1:0];
                    acc_lo_d = {acc_lo_q[WORD_LEN-2:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[WORD_LEN:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WORD_LEN-1:1]};
                end
                if (cnt_q == LastIter) state_d = StFix;
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (bus.flush) state_d = StIdle;
    end

    // Sign fix-up, evaluated in FIX and latched into hi/lo on entry to DONE.
    logic [2*WORD_LEN-1:0] prod, prod_fix;
    logic                  neg_res;
    logic [WORD_LEN-1:0]   res_hi, res_lo;

    assign prod     = {acc_hi_q, acc_lo_q};
    assign neg_res  = neg_a_q ^ neg_b_q;
    assign prod_fix = neg_res ? -prod : prod;

    always_comb begin
        res_hi = prod_fix[2*WORD_LEN-1:WORD_LEN];
        res_lo = prod_fix[WORD_LEN-1:0];
        if (is_div) begin
            if (b_q == '0) begin
                // Divide by zero: defined result rather than whatever the loop left.
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = neg_a_q ? -acc_hi_q : acc_hi_q;
                res_lo = neg_res ? -acc_lo_q : acc_lo_q;
            end
        end
    end

    assign load_res = (state_q == StFix) && (state_d == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvs_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            dvs_q    <= dvs_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            cnt_q    <= cnt_d;
            if (capture) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
            if (load_res) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = (state_q == StDone);
    // DONE already presents the fresh result, so a read there needs no interlock.
    assign bus.stall = bus.busy && !bus.done && (bus.read_hilo || bus.start);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios with literal results,
// then randomized traffic checked every cycle against a cycle-count/arithmetic model.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_ctrl_if #(.WORD_LEN(32)) bus ();

    muldiv_ctrl #(.WORD_LEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {hi, lo} an operation must produce, from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: p = sa * sb;
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Model: age counts cycles since acceptance (0 = idle, 35 = done cycle).
    int          age = 0;
    logic [63:0] pend = '0;
    logic [31:0] m_hi = '0, m_lo = '0;

    always @(posedge clk) begin
        if (rst) begin
            age  <= 0;
            m_hi <= '0;
            m_lo <= '0;
        end else if (age == 0) begin
            if (bus.start && !bus.flush) begin
                age  <= 1;
                pend <= ref_result(bus.op, bus.a, bus.b);
            end
        end else if (bus.flush || age == 35) begin
            age <= 0;
        end else begin
            if (age == 34) begin
                m_hi <= pend[63:32];
                m_lo <= pend[31:0];
            end
            age <= age + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", bus.busy, age != 0);
            chk("done", bus.done, age == 35);
            chk("stall", bus.stall, (age != 0) && (age != 35) && (bus.read_hilo || bus.start));
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
        end
    end

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at cycle T, then watch 40 cycles. Optional flush/reset at T+k and
    // stray starts / HI-LO reads during the operation.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int flush_at, input int rst_at, input bit poke,
                          output int done_at, output logic [31:0] dhi, output logic [31:0] dlo);
        done_at = -1;
        dhi = '0;
        dlo = '0;
        @(posedge clk);
        #1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.flush = 1'b0;
            bus.read_hilo = 1'b0;
            rst = 1'b0;
            if (poke && (k == 5 || k == 20)) begin
                bus.start = 1'b1;
                bus.op = 2'($urandom);
                bus.a = $urandom;
                bus.b = $urandom;
            end
            if (poke && (k == 10 || k == 35)) bus.read_hilo = 1'b1;
            if (k == flush_at) bus.flush = 1'b1;
            if (k == rst_at) rst = 1'b1;
            @(negedge clk);
            if (bus.done && done_at < 0) begin
                done_at = k;
                dhi = bus.hi;
                dlo = bus.lo;
            end
            if (k == 1) chk("busy_at_t1", bus.busy, 1);
            if (poke && k == 10) chk("stall_read_busy", bus.stall, 1);
            if (poke && k == 35) chk("stall_read_done", bus.stall, 0);
            if (flush_at > 0 && k == flush_at + 1) chk("busy_after_flush", bus.busy, 0);
            if (rst_at > 0 && k == rst_at + 1) begin
                chk("busy_after_rst", bus.busy, 0);
                chk("done_after_rst", bus.done, 0);
                chk("hilo_after_rst", {bus.hi, bus.lo}, 64'd0);
            end
        end
    endtask

    int          dat;
    logic [31:0] rh, rl;

    initial begin
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        bus.read_hilo = 1'b0;

        chk("model_multu_max", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
            64'hFFFF_FFFE_0000_0001);
        chk("model_div_ovf", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF),
            64'h0000_0000_8000_0000);
        chk("model_div_neg", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.read_hilo = 1'b1;
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("reset_stall_idle", bus.stall, 0);
        @(posedge clk);
        #1;
        bus.read_hilo = 1'b0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, dat, rh, rl);
        chk("multu_latency", 64'(dat), 64'd35);
        chk("multu_result", {rh, rl}, 64'hFFFF_FFFE_0000_0001);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, dat, rh, rl);
        chk("mult_latency", 64'(dat), 64'd35);
        chk("mult_result", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, dat, rh, rl);
        chk("div_neg_result", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(2'b11, 32'd5, 32'd0, 0, 0, 0, dat, rh, rl);
        chk("divu_zero_latency", 64'(dat), 64'd35);
        chk("divu_zero_result", {rh, rl}, 64'h0000_0005_FFFF_FFFF);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, dat, rh, rl);
        chk("div_ovf_result", {rh, rl}, 64'h0000_0000_8000_0000);

        run_op(2'b11, 32'd100, 32'd7, 0, 0, 1, dat, rh, rl);
        chk("ignore_start_latency", 64'(dat), 64'd35);
        chk("ignore_start_result", {rh, rl}, 64'h0000_0002_0000_000E);

        run_op(2'b01, 32'd3, 32'd4, 10, 0, 0, dat, rh, rl);
        chk("flush_no_done", dat < 0, 1);
        chk("flush_hilo_kept", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

        run_op(2'b01, 32'd3, 32'd4, 0, 0, 0, dat, rh, rl);
        chk("after_flush_latency", 64'(dat), 64'd35);
        chk("after_flush_result", {rh, rl}, 64'd12);

        run_op(2'b10, 32'hFFFF_FF00, 32'd3, 0, 20, 0, dat, rh, rl);
        chk("rst_no_done", dat < 0, 1);

        run_op(2'b11, 32'd9, 32'd3, 0, 0, 0, dat, rh, rl);
        chk("after_rst_latency", 64'(dat), 64'd35);
        chk("after_rst_result", {rh, rl}, 64'd3);

        // Random traffic: starts, stray starts while busy, reads, flushes, rare resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 599) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 79) == 0);
            bus.read_hilo = 1'($urandom_range(0, 1));
            bus.op = 2'($urandom);
            bus.a = rand_word();
            bus.b = rand_word();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.read_hilo = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, operand and result width; all other widths derive from it.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  input  WORD_LEN  multiplicand or dividend; captured when start is accepted.
REQ-007 SHALL have port b  input  WORD_LEN  multiplier or divisor; captured when start is accepted.
REQ-008 SHALL have port flush  input  1  abort any in-flight operation.
REQ-009 SHALL have port read_hilo  input  1  pipeline requests HI/LO this cycle (MFHI/MFLO).
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse; hi/lo hold the new result in the same cycle.
REQ-012 SHALL have port stall  output  1  pipeline interlock.
REQ-013 SHALL have port hi  output  WORD_LEN  HI register: upper product word, or remainder.
REQ-014 SHALL have port lo  output  WORD_LEN  LO register: lower product word, or quotient.

Function
REQ-015 SHALL implement states IDLE, PREP, CALC, FIX and DONE.
REQ-016 SHALL, in IDLE with start=1 and flush=0 in cycle T, capture a, b and op and enter PREP at T+1.
REQ-017 SHALL, in PREP, convert captured operands to magnitudes for signed ops (op[0]=0), record the result signs and clear the iteration counter.
REQ-018 SHALL, in CALC, perform exactly WORD_LEN iterations, one per cycle (T+2..T+33 for WORD_LEN=32): shift-add multiply, or restoring divide (subtract, keep if non-negative).
REQ-019 SHALL, in FIX at T+34, negate results as required by the signs: product if operand signs differ; quotient if signs differ; remainder if dividend negative.
REQ-020 SHALL enter DONE at T+35, update hi/lo and assert done for that cycle only, then return to IDLE at T+36.
REQ-021 SHALL use the same fixed latency for all ops and operand values, including divide by zero.
REQ-022 SHALL, for divide by zero (b=0, DIV or DIVU), produce lo=all ones and hi=a as captured.
REQ-023 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0 with no exception.
REQ-024 SHALL ignore start while busy=1; captured operands and progress are unaffected.
REQ-025 SHALL, on flush=1 in any non-IDLE state, be in IDLE next cycle with no done pulse and hi/lo unchanged.
REQ-026 SHALL give flush priority over start in IDLE: the operation is not accepted.
REQ-027 SHALL change hi/lo only in DONE; they hold their values otherwise.
REQ-028 SHALL drive stall = busy AND NOT done AND (read_hilo OR start), combinationally.
REQ-029 SHALL keep stall low when the DONE-cycle result is read (read_hilo=1 in DONE).

Reset
REQ-030 SHALL, with rst=1 at a clock edge, force state IDLE; busy=0, done=0, hi=0, lo=0 and counter=0.
REQ-031 SHALL give rst priority over flush and start, including mid-operation: no done pulse, result discarded.
REQ-032 SHALL drive stall=0 while state is IDLE after reset.

Verification
REQ-033 SHALL pass: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at T -> done at T+35 only, hi=0xFFFFFFFE, lo=0x00000001, busy high T+1..T+35.
REQ-034 SHALL pass: MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 SHALL pass: DIVU a=5, b=0 -> done at T+35, lo=0xFFFFFFFF, hi=0x00000005; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 SHALL pass: start new ops at T+5 and T+20 during busy -> both ignored, first result correct at T+35; read_hilo=1 at T+10 -> stall=1; read_hilo=1 at T+35 -> stall=0.
REQ-037 SHALL pass: flush at T+10 -> busy=0 at T+11, done never pulses, hi/lo keep prior values; next start accepted normally.
REQ-038 SHALL pass: rst at T+20 mid-CALC -> IDLE next cycle, hi=lo=0, done=0; start after reset completes at 35-cycle latency.
